// File: rtl/spi_pkg.sv
// Shared types and constants for the parametrised SPI slave front-end.
// Holds the FSM state set, command codes and the bit-counter width helper.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA,
        WAIT_TX,
        SEND
    } state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    function automatic int cnt_w(input int data_w);
        return $clog2(data_w + 3);
    endfunction

endpackage

// File: rtl/spi_slave_gen_piso.sv
// Parallel-in serial-out shifter for the MISO path.
// done flags the cycle in which the last bit is presented on bit_o.
module spi_piso #(
    parameter int DATA_W    = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    input  logic              en,
    output logic              bit_o,
    output logic              done
);

    localparam int C_W = $clog2(DATA_W);

    logic [DATA_W-1:0] sr;
    logic [C_W-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (!arst_n || clr) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= din;
            cnt <= '0;
        end else if (en) begin
            sr  <= LSB_FIRST ? (sr >> 1) : (sr << 1);
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_o = LSB_FIRST ? sr[0] : sr[DATA_W-1];
    assign done  = (cnt == C_W'(DATA_W - 1));

endmodule

// File: rtl/spi_slave_gen.sv
// SPI slave front-end for the SPI-to-RAM path: deserialises {cmd, payload}
// frames and returns read data on MISO with a bounded wait for tx_valid.
module spi_slave_gen
    import spi_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter bit MISO_LSB_FIRST = 1'b0,
    parameter int TX_TIMEOUT     = 16
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              rd_addr_held,
    output logic              proto_err
);

    localparam int CNT_W = cnt_w(DATA_W);
    localparam int TMR_W = $clog2(TX_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(DATA_W + 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TX_TIMEOUT - 1);

    state_e           state, state_nx;
    logic [CNT_W-1:0] bit_cnt;
    logic [TMR_W-1:0] tmr;
    logic             hold;
    logic             abort, rx_en, rx_last, tmo, cmd_err;
    logic             ps_load, ps_en, ps_bit, ps_done;
    logic [1:0]       cmd_in;

    // hold marks "frame work finished, wait for ss_n to rise"
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            tmr          <= '0;
            hold         <= 1'b0;
            miso         <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_held <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            state    <= state_nx;
            rx_valid <= rx_last;
            if (abort) begin
                bit_cnt <= '0;
                tmr     <= '0;
                hold    <= 1'b0;
                miso    <= 1'b0;
                rx_data <= '0;
            end else begin
                if (rx_en) begin
                    rx_data <= {rx_data[DATA_W:0], mosi};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if (rx_last) begin
                    bit_cnt <= '0;
                    hold    <= (state != READ_DATA);
                    if (state == READ_ADD) rd_addr_held <= 1'b1;
                    if (cmd_err) proto_err <= 1'b1;
                end
                if (state == WAIT_TX && !hold && !tx_valid)
                    tmr <= tmr + 1'b1;
                if (tmo) begin
                    hold      <= 1'b1;
                    miso      <= 1'b0;
                    proto_err <= 1'b1;
                end
                if (ps_en) begin
                    miso <= ps_bit;
                    if (ps_done) hold <= 1'b1;
                end
                if (state == SEND && hold) begin
                    miso         <= 1'b0;
                    rd_addr_held <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (!ss_n) state_nx = CHK_CMD;
            CHK_CMD:   state_nx = !mosi ? WRITE :
                                  (rd_addr_held ? READ_DATA : READ_ADD);
            READ_DATA: if (rx_last) state_nx = WAIT_TX;
            WAIT_TX:   if (ps_load) state_nx = SEND;
            default:   state_nx = state;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_comb begin
        cmd_in  = rx_data[DATA_W -: 2];
        abort   = ss_n && (state != IDLE);
        rx_en   = !abort && !hold &&
                  (state inside {WRITE, READ_ADD, READ_DATA});
        rx_last = rx_en && (bit_cnt == LAST);
        tmo     = !abort && !hold && state == WAIT_TX &&
                  !tx_valid && tmr == TMO_LAST;
        ps_load = !abort && !hold && state == WAIT_TX && tx_valid;
        ps_en   = !abort && !hold && state == SEND;
        unique case (state)
            WRITE:     cmd_err = cmd_in[1];
            READ_ADD:  cmd_err = !cmd_in[1];
            READ_DATA: cmd_err = (cmd_in != CMD_RD_DATA);
            default:   cmd_err = 1'b0;
        endcase
    end

    spi_piso #(
        .DATA_W   (DATA_W),
        .LSB_FIRST(MISO_LSB_FIRST)
    ) u_piso (
        .clk   (clk),
        .arst_n(arst_n),
        .clr   (abort),
        .load  (ps_load),
        .din   (tx_data),
        .en    (ps_en),
        .bit_o (ps_bit),
        .done  (ps_done)
    );

endmodule

// File: tb/tb_spi_slave_gen.sv
// Directed bench for spi_slave_gen: 8-bit MSB/LSB-first pair plus a 16-bit slave,
// checked every cycle against a frame-level model and a few literal expectations.
module tb_spi_slave_gen;

    localparam int TMO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       arst_n, ss_n, mosi, tx_valid;
    logic [7:0] tx_data;
    logic       miso_a, miso_b, rxv_a, rxv_b;
    logic       held_a, held_b, err_a, err_b;
    logic [9:0] rxd_a, rxd_b;

    logic        arst_n_c, ss_n_c, mosi_c, tx_valid_c;
    logic [15:0] tx_data_c;
    logic        miso_c, rxv_c, held_c, err_c;
    logic [17:0] rxd_c;

    spi_slave_gen #(.DATA_W(8), .MISO_LSB_FIRST(1'b0), .TX_TIMEOUT(TMO)) u_a (
        .clk(clk), .arst_n(arst_n), .ss_n(ss_n), .mosi(mosi), .miso(miso_a),
        .rx_data(rxd_a), .rx_valid(rxv_a), .tx_data(tx_data),
        .tx_valid(tx_valid), .rd_addr_held(held_a), .proto_err(err_a));

    spi_slave_gen #(.DATA_W(8), .MISO_LSB_FIRST(1'b1), .TX_TIMEOUT(TMO)) u_b (
        .clk(clk), .arst_n(arst_n), .ss_n(ss_n), .mosi(mosi), .miso(miso_b),
        .rx_data(rxd_b), .rx_valid(rxv_b), .tx_data(tx_data),
        .tx_valid(tx_valid), .rd_addr_held(held_b), .proto_err(err_b));

    spi_slave_gen #(.DATA_W(16), .MISO_LSB_FIRST(1'b0), .TX_TIMEOUT(TMO)) u_c (
        .clk(clk), .arst_n(arst_n_c), .ss_n(ss_n_c), .mosi(mosi_c),
        .miso(miso_c), .rx_data(rxd_c), .rx_valid(rxv_c),
        .tx_data(tx_data_c), .tx_valid(tx_valid_c),
        .rd_addr_held(held_c), .proto_err(err_c));

    int   nchk = 0;
    int   nerr = 0;
    bit   chk_en = 1'b0;
    logic exp_rxv = 1'b0, exp_ma = 1'b0, exp_mb = 1'b0;
    logic m_held = 1'b0, m_err = 1'b0;
    logic [9:0]  exp_rxd = '0, cap_rxd = '0;
    logic exp_rxv_c = 1'b0, mc_held = 1'b0, mc_err = 1'b0;
    logic [17:0] exp_rxd_c = '0, cap_rxd_c = '0;
    logic [7:0]  got_a, got_b;
    int   tmo_at;
    bit   to_tx;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rx_valid_a", 32'(rxv_a), 32'(exp_rxv));
            chk("rx_valid_b", 32'(rxv_b), 32'(exp_rxv));
            if (exp_rxv) begin
                chk("rx_data_a", 32'(rxd_a), 32'(exp_rxd));
                chk("rx_data_b", 32'(rxd_b), 32'(exp_rxd));
            end
            chk("miso_a", 32'(miso_a), 32'(exp_ma));
            chk("miso_b", 32'(miso_b), 32'(exp_mb));
            chk("held_a", 32'(held_a), 32'(m_held));
            chk("held_b", 32'(held_b), 32'(m_held));
            chk("err_a", 32'(err_a), 32'(m_err));
            chk("err_b", 32'(err_b), 32'(m_err));
            chk("rx_valid_c", 32'(rxv_c), 32'(exp_rxv_c));
            if (exp_rxv_c)
                chk("rx_data_c", 32'(rxd_c), 32'(exp_rxd_c));
            chk("miso_c", 32'(miso_c), 32'd0);
            chk("held_c", 32'(held_c), 32'(mc_held));
            chk("err_c", 32'(err_c), 32'(mc_err));
        end
    end

    task automatic cyc(input logic s, input logic m, input logic tv);
        ss_n = s; mosi = m; tx_valid = tv;
        @(posedge clk); #1;
        exp_rxv = 1'b0; exp_ma = 1'b0; exp_mb = 1'b0;
    endtask

    // Frame of selector + 10 bits; nbits < 10 raises ss_n on the next bit
    task automatic ab_frame(input logic sel, input logic [9:0] w,
                            input int nbits, output bit rd);
        rd = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, sel, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            cyc(1'b0, w[9-i], 1'b0);
            if (i == 9) begin
                exp_rxv = 1'b1; exp_rxd = w; cap_rxd = rxd_a;
                if (!sel) m_err = m_err | w[9];
                else if (!m_held) begin
                    m_err = m_err | ~w[9]; m_held = 1'b1;
                end else begin
                    m_err = m_err | (w[9:8] != 2'b11); rd = 1'b1;
                end
            end
        end
        if (nbits < 10) cyc(1'b1, w[9-nbits], 1'b0);
    endtask

    // k > 0: tx_valid sampled k cycles after rx_valid; k = 0: never
    task automatic tx_phase(input int k, input logic [7:0] d, input int tail);
        got_a = '0; got_b = '0; tmo_at = -1; tx_data = d;
        if (k > 0) begin
            for (int j = 1; j < k; j++) cyc(1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b1);
            for (int b = 1; b <= 8; b++) begin
                cyc(1'b0, 1'b0, 1'b0);
                exp_ma = d[8-b]; exp_mb = d[b-1];
                got_a = {got_a[6:0], miso_a};
                got_b = {got_b[6:0], miso_b};
            end
            cyc(1'b0, 1'b0, 1'b0);
            m_held = 1'b0;
        end else begin
            for (int j = 1; j <= TMO + tail; j++) begin
                cyc(1'b0, 1'b0, 1'b0);
                if (j == TMO) m_err = 1'b1;
                if (err_a === 1'b1 && tmo_at < 0) tmo_at = j;
            end
        end
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic cyc_c(input logic s, input logic m);
        ss_n_c = s; mosi_c = m;
        @(posedge clk); #1;
        exp_rxv_c = 1'b0;
    endtask

    task automatic c_frame(input logic sel, input logic [17:0] w,
                           input int nbits);
        cyc_c(1'b0, 1'b0);
        cyc_c(1'b0, sel);
        for (int i = 0; i < nbits; i++) begin
            cyc_c(1'b0, w[17-i]);
            if (i == 17) begin
                exp_rxv_c = 1'b1; exp_rxd_c = w; cap_rxd_c = rxd_c;
                if (!sel) mc_err = mc_err | w[17];
                else if (!mc_held) begin
                    mc_err = mc_err | ~w[17]; mc_held = 1'b1;
                end else mc_err = mc_err | (w[17:16] != 2'b11);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        tx_valid = 1'b0; tx_data = '0;
        arst_n_c = 1'b0; ss_n_c = 1'b1; mosi_c = 1'b0;
        tx_valid_c = 1'b0; tx_data_c = '0;
        cyc(1'b1, 1'b0, 1'b0);
        chk_en = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        arst_n = 1'b1; arst_n_c = 1'b1;
        chk("reset_rx_data_a", 32'(rxd_a), 32'd0);
        chk("reset_rx_data_c", 32'(rxd_c), 32'd0);

        ab_frame(1'b0, 10'h0A5, 10, to_tx);
        chk("wr_addr_rx_data", 32'(cap_rxd), 32'h0A5);
        cyc(1'b1, 1'b0, 1'b0);

        ab_frame(1'b1, 10'b10_0000_0011, 10, to_tx);
        cyc(1'b1, 1'b0, 1'b0);
        chk("rd_addr_held_set", 32'(held_a), 32'd1);

        ab_frame(1'b1, 10'b11_0101_0101, 10, to_tx);
        chk("rd_data_path", 32'(to_tx), 32'd1);
        tx_phase(2, 8'hC3, 0);
        chk("miso_seq_msb", 32'(got_a), 32'hC3);
        chk("miso_seq_lsb", 32'(got_b), 32'hC3);
        chk("rd_addr_held_clr", 32'(held_a), 32'd0);

        ab_frame(1'b1, 10'b10_1111_0000, 10, to_tx);
        cyc(1'b1, 1'b0, 1'b0);
        ab_frame(1'b1, 10'b11_0000_1111, 10, to_tx);
        tx_phase(TMO, 8'h4D, 0);
        chk("tx_at_timeout_msb", 32'(got_a), 32'h4D);
        chk("tx_at_timeout_lsb", 32'(got_b), 32'hB2);
        chk("tx_at_timeout_err", 32'(err_a), 32'd0);

        ab_frame(1'b1, 10'b10_0000_0001, 10, to_tx);
        cyc(1'b1, 1'b0, 1'b0);
        ab_frame(1'b1, 10'b11_1111_1111, 5, to_tx);
        chk("abort_held_kept", 32'(held_a), 32'd1);
        ab_frame(1'b0, 10'b00_1100_1100, 9, to_tx);

        ab_frame(1'b1, 10'b11_1010_1010, 10, to_tx);
        tx_phase(0, 8'h00, 4);
        chk("timeout_cycle", 32'(tmo_at), 32'd16);
        ab_frame(1'b0, 10'b01_0011_1100, 10, to_tx);
        cyc(1'b1, 1'b0, 1'b0);
        chk("err_sticky", 32'(err_a), 32'd1);

        arst_n = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        m_held = 1'b0; m_err = 1'b0;
        arst_n = 1'b1;
        ab_frame(1'b0, 10'b10_0110_0110, 10, to_tx);
        cyc(1'b1, 1'b0, 1'b0);
        chk("sel0_cmd10_err", 32'(err_a), 32'd1);

        c_frame(1'b1, {2'b00, 16'h1234}, 18);
        cyc_c(1'b1, 1'b0);
        c_frame(1'b0, {2'b01, 16'hBEEF}, 18);
        chk("c_rx_data_beef", 32'(cap_rxd_c), 32'h1BEEF);
        cyc_c(1'b1, 1'b0);
        c_frame(1'b0, 18'h1FFFF, 7);
        arst_n_c = 1'b0;
        cyc_c(1'b0, 1'b1);
        mc_held = 1'b0; mc_err = 1'b0;
        chk("c_reset_rx_data", 32'(rxd_c), 32'd0);
        chk("c_reset_held", 32'(held_c), 32'd0);
        chk("c_reset_err", 32'(err_c), 32'd0);
        arst_n_c = 1'b1;
        cyc_c(1'b1, 1'b0);
        cyc_c(1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
